// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Arbitrates two register-file write requesters onto one registered write
//   port. Grants are combinational; the granted write appears on the output
//   registers one cycle after the transfer edge. Ties between requesters are
//   broken by a round-robin pointer that moves to the non-granted requester
//   after every transfer.
//
//   Optional feature (define REGFILE_ARB_CLEAR_EN): a CLEAR state that sweeps
//   CLEAR_VALUE into every register, one per cycle, starting from register 0.
//   It is entered on reset exit and on clearReq while arbitrating. Without the
//   macro the block only arbitrates, clearReq is ignored and busy is tied 0.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req0/req1           write requests
//   wrSel0/wrSel1       target register of each requester
//   wrData0/wrData1     write data of each requester
//   gnt0/gnt1           combinational grants (transfer when reqN && gntN)
//   clearReq            request a full clear sweep
//   busy                high for the cycles that carry sweep writes
//   regWriteSel         registered write select
//   writeEnable         registered write enable
//   writeData           registered write data
module regfile_write_arbiter #(
  parameter int unsigned               DATA_WIDTH  = 32,
  parameter int unsigned               SEL_WIDTH   = 5,
  parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [SEL_WIDTH-1:0]  wrSel0,
  input  logic [SEL_WIDTH-1:0]  wrSel1,
  input  logic [DATA_WIDTH-1:0] wrData0,
  input  logic [DATA_WIDTH-1:0] wrData1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  clearReq,
  output logic                  busy,
  output logic [SEL_WIDTH-1:0]  regWriteSel,
  output logic                  writeEnable,
  output logic [DATA_WIDTH-1:0] writeData
);

  logic                  ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  arb_ok;

`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  // busy is registered alongside the write outputs so that it covers exactly
  // the cycles carrying sweep writes and drops together with writeEnable.
  // Grants stay blocked while busy so no grant is seen during a sweep.
  assign arb_ok = !reset && (state_q == ARB) && !clearReq && !busy_q;
  assign busy   = busy_q;
`else
  logic unused_clear_req;

  assign unused_clear_req = clearReq;
  assign arb_ok           = !reset;
  assign busy             = 1'b0;
`endif

  // The pointer only decides ties; a lone requester always wins.
  always_comb begin
    gnt0 = arb_ok && req0 && (!req1 || !ptr_q);
    gnt1 = arb_ok && req1 && (!req0 ||  ptr_q);
  end

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    sel_d  = sel_q;
    data_d = data_q;
`ifdef REGFILE_ARB_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
`endif

    if (gnt0) begin
      we_d   = 1'b1;
      sel_d  = wrSel0;
      data_d = wrData0;
      ptr_d  = 1'b1;
    end else if (gnt1) begin
      we_d   = 1'b1;
      sel_d  = wrSel1;
      data_d = wrData1;
      ptr_d  = 1'b0;
    end

`ifdef REGFILE_ARB_CLEAR_EN
    unique case (state_q)
      ARB: begin
        if (clearReq) state_d = CLEAR;
      end
      CLEAR: begin
        we_d   = 1'b1;
        sel_d  = cnt_q;
        data_d = CLEAR_VALUE;
        busy_d = 1'b1;
        // Counter wraps naturally to 0 after the last register.
        cnt_d  = cnt_q + SEL_WIDTH'(1);
        if (cnt_q == '1) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
`ifdef REGFILE_ARB_CLEAR_EN
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
`endif
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      sel_q  <= sel_d;
      data_q <= data_d;
`ifdef REGFILE_ARB_CLEAR_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
`endif
    end
  end

  assign writeEnable = we_q;
  assign regWriteSel = sel_q;
  assign writeData   = data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter. A behavioural model decides
// grants and the write each cycle should produce; that write is pushed to a
// scoreboard queue and popped once the DUT outputs update after the edge.
// Sweep-specific scenarios are built when REGFILE_ARB_CLEAR_EN is defined.
module tb_regfile_write_arbiter;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = 5;
  localparam int unsigned NREG = 1 << SW;
  localparam logic [DW-1:0] CV = 32'h0000_0000;
`ifdef REGFILE_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, req0, req1, clearReq;
  logic [SW-1:0] wrSel0, wrSel1;
  logic [DW-1:0] wrData0, wrData1;
  logic          gnt0, gnt1, busy, writeEnable;
  logic [SW-1:0] regWriteSel;
  logic [DW-1:0] writeData;

  regfile_write_arbiter #(
    .DATA_WIDTH (DW),
    .SEL_WIDTH  (SW),
    .CLEAR_VALUE(CV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .wrSel0     (wrSel0),
    .wrSel1     (wrSel1),
    .wrData0    (wrData0),
    .wrData1    (wrData1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .clearReq   (clearReq),
    .busy       (busy),
    .regWriteSel(regWriteSel),
    .writeEnable(writeEnable),
    .writeData  (writeData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Model state
  bit            m_clear;
  int unsigned   m_cnt;
  bit            m_ptr;
  bit            m_busy;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_data;
  logic [DW-1:0] shadow [NREG];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check grants/busy, push expected write,
  // then pop and compare after the rising edge.
  task automatic step(input logic rst, input logic r0, input logic r1, input logic clr,
                      input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      output logic og0, output logic og1);
    wr_t  e;
    bit   eg0, eg1, nbusy;
    reset = rst; req0 = r0; req1 = r1; clearReq = clr;
    wrSel0 = s0; wrSel1 = s1; wrData0 = d0; wrData1 = d1;
    #1;
    eg0 = 1'b0; eg1 = 1'b0; nbusy = 1'b0;
    if (rst) begin
      e = '0; m_ptr = 1'b0; m_cnt = 0; m_clear = CLR_EN;
    end else if (m_clear) begin
      e = {1'b1, SW'(m_cnt), CV};
      nbusy = 1'b1;
      if (m_cnt == NREG - 1) begin m_cnt = 0; m_clear = 1'b0; end
      else m_cnt++;
    end else begin
      if (!(clr && CLR_EN) && !m_busy) begin
        if (r0 && (!r1 || !m_ptr)) eg0 = 1'b1;
        else if (r1) eg1 = 1'b1;
      end
      if (eg0) begin e = {1'b1, s0, d0}; m_ptr = 1'b1; end
      else if (eg1) begin e = {1'b1, s1, d1}; m_ptr = 1'b0; end
      else e = {1'b0, m_sel, m_data};
      if (clr && CLR_EN) m_clear = 1'b1;
    end
    check("gnt0", 64'(gnt0), 64'(eg0));
    check("gnt1", 64'(gnt1), 64'(eg1));
    check("busy", 64'(busy), 64'(m_busy));
    og0 = gnt0; og1 = gnt1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("writeEnable", 64'(writeEnable), 64'(e.we));
    check("regWriteSel", 64'(regWriteSel), 64'(e.sel));
    check("writeData",   64'(writeData),   64'(e.data));
    if (writeEnable === 1'b1) shadow[regWriteSel] = writeData;
    m_busy = nbusy; m_sel = e.sel; m_data = e.data;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    logic g0, g1;
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0, '0, g0, g1);
  endtask

  initial begin
    logic g0, g1;
    logic [7:0] pat;
    int unsigned nb;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; clearReq = 1'b0;
    wrSel0 = '0; wrSel1 = '0; wrData0 = '0; wrData1 = '0;
    m_clear = CLR_EN; m_cnt = 0; m_ptr = 1'b0; m_busy = 1'b0; m_sel = '0; m_data = '0;
    for (int unsigned i = 0; i < NREG; i++) shadow[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset holds everything quiet even with requests pending
    step(1, 1, 1, 1, 5'd3, 5'd4, 32'hAAAA_0001, 32'hBBBB_0002, g0, g1);
    check("reset_gnt", 64'({g0, g1}), 64'(0));
    step(1, 1, 1, 0, 5'd3, 5'd4, 32'hAAAA_0001, 32'hBBBB_0002, g0, g1);
    check("reset_we", 64'(writeEnable), 64'(0));
    check("reset_sel", 64'(regWriteSel), 64'(0));

`ifdef REGFILE_ARB_CLEAR_EN
    // Reset-exit sweep: busy counted over the sweep window
    nb = 0;
    for (int unsigned i = 0; i < NREG + 1; i++) begin
      step(0, 0, 0, 0, '0, '0, '0, '0, g0, g1);
      if (busy === 1'b1) nb++;
    end
    check("sweep_busy_cycles", 64'(nb), 64'(NREG));
    idle(1);
`else
    // First request granted in the first post-reset cycle; busy stays 0
    step(0, 0, 1, 0, '0, 5'd9, '0, 32'h0000_0909, g0, g1);
    check("first_gnt1", 64'(g1), 64'(1));
    check("noclr_busy", 64'(busy), 64'(0));
`endif

    // Single requester, same-cycle grant, one-cycle write latency
    step(0, 1, 0, 0, 5'd5, '0, 32'hFFFF_000F, '0, g0, g1);
    check("single_gnt0", 64'(g0), 64'(1));
    check("single_sel", 64'(regWriteSel), 64'(5));
    check("single_data", 64'(writeData), 64'(32'hFFFF_000F));
    idle(1);
    check("idle_hold_sel", 64'(regWriteSel), 64'(5));
    step(0, 0, 1, 0, '0, 5'd7, '0, 32'h0000_1234, g0, g1);

    // Both held after reset: grants alternate 0,1,0,1
    step(1, 0, 0, 0, '0, '0, '0, '0, g0, g1);
`ifdef REGFILE_ARB_CLEAR_EN
    idle(NREG + 1);
`endif
    pat = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 5'(i), 5'(i + 8), 32'(i), 32'(i + 100), g0, g1);
      pat = {pat[5:0], g0, g1};
    end
    check("rr_pattern", 64'(pat), 64'(8'b10_01_10_01));

    // Same target: winner first, loser pending then written
    step(0, 1, 1, 0, 5'd3, 5'd3, 32'h0000_000A, 32'h0000_000B, g0, g1);
    check("same_reg_win", 64'({g0, g1}), 64'(2'b10));
    step(0, 0, 1, 0, 5'd3, 5'd3, 32'h0000_000A, 32'h0000_000B, g0, g1);
    check("same_reg_lose", 64'(g1), 64'(1));
    idle(1);
    check("reg3_final", 64'(shadow[3]), 64'(32'h0000_000B));

    // clearReq together with req1
    step(0, 0, 1, 1, '0, 5'd12, '0, 32'hC0DE_0012, g0, g1);
`ifdef REGFILE_ARB_CLEAR_EN
    check("clr_gnt1", 64'(g1), 64'(0));
    idle(10);
    check("sweep_at_9", 64'(regWriteSel), 64'(9));
    step(1, 0, 0, 0, '0, '0, '0, '0, g0, g1);
    idle(1);
    check("restart_sel0", 64'(regWriteSel), 64'(0));
    check("restart_we", 64'(writeEnable), 64'(1));
    idle(NREG + 1);
`else
    check("clr_ignored_gnt1", 64'(g1), 64'(1));
    step(0, 0, 0, 1, '0, '0, '0, '0, g0, g1);
    check("clr_no_write", 64'(writeEnable), 64'(0));
`endif

    // Random traffic against the model
    for (int unsigned i = 0; i < 300; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 39) == 0),
           5'($urandom), 5'($urandom), $urandom, $urandom, g0, g1);
      check("mutex", 64'(g0 & g1), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
